timer_seq_ctrl: RTL and testbench
=================================

Name: timer_seq_ctrl

Overview:
- APB master sequencer that runs the 8-bit timer through one complete measurement: program, start, poll for the event flag, clear.
- Sits between a local requester (test/firmware engine) and the timer's APB slave port.
- Replaces hand-written CPU sequences with one start pulse. Reports done, status and the poll count.

Parameters:
- ADDR_TCR, 8'h00, timer control register address
- ADDR_TDR, 8'h01, timer data (reload) register address
- ADDR_TSR, 8'h02, timer status register address
- POLL_GAP, 16, idle pclk cycles between TSR reads (min 1)
- POLL_MAX, 1024, TSR reads without the flag before timeout (min 1)

Ports:
- pclk  in  1  APB clock, sole clock
- prst  in  1  synchronous active-high reset
- start  in  1  one-cycle request, accepted only when busy=0
- abort  in  1  level; stops the sequence (see Behaviour)
- cfg_tdr  in  8  reload value, sampled on the accepted start
- cfg_dw  in  1  1=count down (wait on udf, TSR[1]); 0=count up (wait on ovf, TSR[0]); sampled on start
- cfg_clk  in  2  timer clock select, sampled on start
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- status  out  2  00 ok, 01 timeout, 10 slverr, 11 aborted; valid from done until the next start
- poll_cnt  out  10  TSR reads performed in the last run
- paddr  out  8  APB address
- pwrite  out  1  APB write
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  8  APB write data
- prdata  in  8  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal counters 0.
- prst mid-transfer: psel/penable drop at the next edge. No completion is reported.
- APB transfer, every transfer:
  - SETUP cycle: psel=1, penable=0, paddr/pwrite/pwdata valid.
  - ACCESS cycles: penable=1 with address and data held, until pready=1.
  - psel and penable return to 0 on the following cycle. No back-to-back ACCESS.
  - Minimum 2 cycles per transfer.
- FSM: IDLE → WR_TDR → WR_LOAD → WR_RUN → GAP → RD_TSR → (CLR | GAP | STOP) → FIN → IDLE.
- Transfers per state:
  - WR_TDR: write ADDR_TDR = cfg_tdr.
  - WR_LOAD: write ADDR_TCR = 8'h80 (load bit).
  - WR_RUN: write ADDR_TCR = {2'b00, cfg_dw, 1'b1, 2'b00, cfg_clk}.
  - GAP: count POLL_GAP cycles, no transfer.
  - RD_TSR: read ADDR_TSR; poll_cnt increments on completion.
  - CLR: write ADDR_TSR = 8'h00, then status=ok.
  - STOP: write ADDR_TCR = 8'h00.
  - FIN: done=1 for one cycle; busy falls in the same cycle.
- Exit from RD_TSR:
  - Target flag bit set → CLR.
  - Flag clear and poll_cnt < POLL_MAX → GAP.
  - Flag clear and poll_cnt = POLL_MAX → STOP with status=timeout.
  - Non-target TSR bits are ignored.
- busy: rises the cycle after an accepted start. start while busy=1 is ignored, with no queueing.
- pslverr=1 at a completing transfer: go to FIN with status=slverr. No further transfers, and no STOP write.
- abort:
  - An in-flight APB transfer always completes first; it cannot be cut.
  - Then STOP is performed with status=aborted.
  - abort in GAP takes effect on the next cycle.
  - abort in IDLE has no effect.
  - abort and flag seen in the same RD_TSR completion: abort wins.
- poll_cnt: saturates at POLL_MAX; cleared on an accepted start.

Decomposition:
- Shared package timer_pkg: TCR/TDR/TSR addresses, TCR bit positions (load 7, dw 5, en 4, clk_sel 1:0), TSR bits (ovf 0, udf 1), status encodings, FSM state enum.
- One sub-module, apb_xfer_master: single-transfer engine. Inputs req/addr/wr/wdata; outputs ack/rdata/err; owns the SETUP/ACCESS timing.
- The top-level FSM only sequences requests to apb_xfer_master.

Test Plan:
- Down count: start with cfg_tdr=8'hFF, cfg_dw=1, cfg_clk=2, slave pready=1. Expect writes (01,FF), (00,80), (00,32); TSR reads until the slave returns 02; write (02,00); done with status=00; poll_cnt equals the reads issued.
- Up count: cfg_dw=0, cfg_clk=0, cfg_tdr=8'hF0. Expect TCR run write 8'h10. A TSR read of 02 does not complete; a read of 01 completes.
- Timeout: POLL_MAX=4, slave always returns TSR=00. Expect exactly 4 reads, then write (00,00); status=01; poll_cnt=4.
- Wait states and error: pready low for 3 cycles on WR_LOAD, then pready=1 with pslverr=1. Expect paddr/pwdata held throughout; no further transfers; status=10; done one cycle.
- Abort and start filtering:
  - abort during a waited TSR read: the read completes, then write (00,00); status=11.
  - start while busy: ignored; no second sequence.
- Reset mid-ACCESS: prst=1 while penable=1. Next cycle psel=penable=busy=done=0. A new start afterwards runs a clean sequence.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer measurement sequencer: register map,
// register bit positions, result codes and state encodings.
package timer_pkg;

  // Default timer register addresses
  localparam logic [7:0] TCR_ADDR_DEF = 8'h00;
  localparam logic [7:0] TDR_ADDR_DEF = 8'h01;
  localparam logic [7:0] TSR_ADDR_DEF = 8'h02;

  // TCR bit positions
  localparam int TCR_LOAD    = 7;
  localparam int TCR_DW      = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CLK_LSB = 0;

  // TSR bit positions
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Completion status reported with done
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_SLVERR  = 2'b10,
    ST_ABORTED = 2'b11
  } status_e;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_TDR  = 4'd1,
    S_WR_LOAD = 4'd2,
    S_WR_RUN  = 4'd3,
    S_GAP     = 4'd4,
    S_RD_TSR  = 4'd5,
    S_CLR     = 4'd6,
    S_STOP    = 4'd7,
    S_FIN     = 4'd8
  } seq_state_e;

  // APB transfer phases
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } apb_phase_e;

  // TCR word that only pulses the load bit
  function automatic logic [7:0] tcr_load_word();
    logic [7:0] w;
    w = 8'h00;
    w[TCR_LOAD] = 1'b1;
    return w;
  endfunction

  // TCR word that enables counting with the chosen direction and clock
  function automatic logic [7:0] tcr_run_word(input logic dw, input logic [1:0] clk_sel);
    logic [7:0] w;
    w = 8'h00;
    w[TCR_DW] = dw;
    w[TCR_EN] = 1'b1;
    w[TCR_CLK_LSB +: 2] = clk_sel;
    return w;
  endfunction

endpackage

// File: rtl/apb_xfer_master.sv
// Single APB transfer engine: accepts one request while idle, runs the
// SETUP/ACCESS handshake and returns a registered ack with read data and
// error one cycle after the completing ACCESS cycle.
module apb_xfer_master
  import timer_pkg::*;
(
  input  logic       pclk,
  input  logic       prst,
  input  logic       req,
  input  logic [7:0] addr,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       err,
  output logic [7:0] paddr,
  output logic       pwrite,
  output logic       psel,
  output logic       penable,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  apb_phase_e phase_q, phase_d;
  logic [7:0] addr_q;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic       ack_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       complete;

  assign complete = (phase_q == PH_ACCESS) && pready;

  // Phase sequencing: a request is only taken while idle, ACCESS holds until pready
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:   if (req) phase_d = PH_SETUP;
      PH_SETUP:  phase_d = PH_ACCESS;
      PH_ACCESS: if (pready) phase_d = PH_IDLE;
      default:   phase_d = PH_IDLE;
    endcase
  end

  // Phase register, request capture and completion result
  always_ff @(posedge pclk) begin
    if (prst) begin
      phase_q <= PH_IDLE;
      addr_q  <= 8'h00;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ack_q   <= complete;
      err_q   <= complete && pslverr;
      if (complete) rdata_q <= prdata;
      if ((phase_q == PH_IDLE) && req) begin
        addr_q  <= addr;
        wr_q    <= wr;
        wdata_q <= wdata;
      end
    end
  end

  assign psel    = (phase_q != PH_IDLE);
  assign penable = (phase_q == PH_ACCESS);
  assign paddr   = addr_q;
  assign pwrite  = wr_q;
  assign pwdata  = wdata_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: rtl/timer_seq_ctrl.sv
// Runs one complete timer measurement over APB: load reload value, load,
// run, poll the event flag with idle gaps, then clear or stop the timer.
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter logic [7:0] ADDR_TCR = TCR_ADDR_DEF,
  parameter logic [7:0] ADDR_TDR = TDR_ADDR_DEF,
  parameter logic [7:0] ADDR_TSR = TSR_ADDR_DEF,
  parameter int         POLL_GAP = 16,
  parameter int         POLL_MAX = 1024
) (
  input  logic       pclk,
  input  logic       prst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_tdr,
  input  logic       cfg_dw,
  input  logic [1:0] cfg_clk,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [9:0] poll_cnt,
  output logic [7:0] paddr,
  output logic       pwrite,
  output logic       psel,
  output logic       penable,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam int PCW = $clog2(POLL_MAX + 1);

  seq_state_e     state_q, state_d;
  status_e        status_q, status_d;
  logic [7:0]     tdr_q;
  logic           dw_q;
  logic [1:0]     clk_q;
  logic [GW-1:0]  gap_cnt_q;
  logic [PCW-1:0] poll_cnt_q;
  logic           issued_q;
  logic           abort_q;

  logic           xfer_req;
  logic [7:0]     xfer_addr;
  logic           xfer_wr;
  logic [7:0]     xfer_wdata;
  logic           xfer_ack;
  logic [7:0]     xfer_rdata;
  logic           xfer_err;

  logic           abort_hit;
  logic           gap_done;
  logic           last_poll;
  logic [7:0]     flag_mask;
  logic           tsr_flag;

  // Abort is a level; remember it so a short pulse during a transfer still counts
  assign abort_hit = abort || abort_q;
  assign gap_done  = (gap_cnt_q == GW'(POLL_GAP - 1));
  // The read completing now is the POLL_MAX-th one
  assign last_poll = (poll_cnt_q >= PCW'(POLL_MAX - 1));
  assign flag_mask = dw_q ? (8'h01 << TSR_UDF) : (8'h01 << TSR_OVF);
  assign tsr_flag  = |(xfer_rdata & flag_mask);

  // State and result registers
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  // Next state and result code; an errored transfer ends the run without STOP
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WR_TDR;
          status_d = ST_OK;
        end
      end
      S_WR_TDR, S_WR_LOAD, S_WR_RUN, S_CLR: begin
        if (xfer_ack) begin
          if (xfer_err) begin
            state_d  = S_FIN;
            status_d = ST_SLVERR;
          end else if (abort_hit) begin
            state_d  = S_STOP;
            status_d = ST_ABORTED;
          end else if (state_q == S_WR_TDR) begin
            state_d = S_WR_LOAD;
          end else if (state_q == S_WR_LOAD) begin
            state_d = S_WR_RUN;
          end else if (state_q == S_WR_RUN) begin
            state_d = S_GAP;
          end else begin
            state_d  = S_FIN;
            status_d = ST_OK;
          end
        end
      end
      S_GAP: begin
        if (abort_hit) begin
          state_d  = S_STOP;
          status_d = ST_ABORTED;
        end else if (gap_done) begin
          state_d = S_RD_TSR;
        end
      end
      S_RD_TSR: begin
        if (xfer_ack) begin
          if (xfer_err) begin
            state_d  = S_FIN;
            status_d = ST_SLVERR;
          end else if (abort_hit) begin
            state_d  = S_STOP;
            status_d = ST_ABORTED;
          end else if (tsr_flag) begin
            state_d = S_CLR;
          end else if (!last_poll) begin
            state_d = S_GAP;
          end else begin
            state_d  = S_STOP;
            status_d = ST_TIMEOUT;
          end
        end
      end
      S_STOP: begin
        if (xfer_ack) begin
          state_d = S_FIN;
          if (xfer_err) status_d = ST_SLVERR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer request and outward flags decoded from the current state
  always_comb begin
    xfer_req   = 1'b0;
    xfer_addr  = 8'h00;
    xfer_wr    = 1'b0;
    xfer_wdata = 8'h00;
    case (state_q)
      S_WR_TDR: begin
        xfer_req   = !issued_q;
        xfer_addr  = ADDR_TDR;
        xfer_wr    = 1'b1;
        xfer_wdata = tdr_q;
      end
      S_WR_LOAD: begin
        xfer_req   = !issued_q;
        xfer_addr  = ADDR_TCR;
        xfer_wr    = 1'b1;
        xfer_wdata = tcr_load_word();
      end
      S_WR_RUN: begin
        xfer_req   = !issued_q;
        xfer_addr  = ADDR_TCR;
        xfer_wr    = 1'b1;
        xfer_wdata = tcr_run_word(dw_q, clk_q);
      end
      S_RD_TSR: begin
        xfer_req  = !issued_q;
        xfer_addr = ADDR_TSR;
      end
      S_CLR: begin
        xfer_req   = !issued_q;
        xfer_addr  = ADDR_TSR;
        xfer_wr    = 1'b1;
        xfer_wdata = 8'h00;
      end
      S_STOP: begin
        xfer_req   = !issued_q;
        xfer_addr  = ADDR_TCR;
        xfer_wr    = 1'b1;
        xfer_wdata = 8'h00;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done   = (state_q == S_FIN);
  assign status = status_q;

  // Configuration capture, poll/gap counters and per-state request bookkeeping
  always_ff @(posedge pclk) begin
    if (prst) begin
      tdr_q      <= 8'h00;
      dw_q       <= 1'b0;
      clk_q      <= 2'b00;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      issued_q   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        tdr_q      <= cfg_tdr;
        dw_q       <= cfg_dw;
        clk_q      <= cfg_clk;
        poll_cnt_q <= '0;
      end else if ((state_q == S_RD_TSR) && xfer_ack && (poll_cnt_q != PCW'(POLL_MAX))) begin
        poll_cnt_q <= poll_cnt_q + 1'b1;
      end

      if (state_q != S_GAP) gap_cnt_q <= '0;
      else                  gap_cnt_q <= gap_cnt_q + 1'b1;

      // One request per visit to a transfer state
      if (state_d != state_q) issued_q <= 1'b0;
      else if (xfer_req)      issued_q <= 1'b1;

      if ((state_q == S_IDLE) || (state_q == S_FIN)) abort_q <= 1'b0;
      else if (abort)                                abort_q <= 1'b1;
    end
  end

  // Present the internal poll count on the 10-bit port, saturating if wider
  generate
    if (PCW < 10) begin : g_pc_narrow
      assign poll_cnt = {{(10 - PCW){1'b0}}, poll_cnt_q};
    end else if (PCW == 10) begin : g_pc_exact
      assign poll_cnt = poll_cnt_q;
    end else begin : g_pc_wide
      assign poll_cnt = (poll_cnt_q > PCW'(1023)) ? 10'h3FF : poll_cnt_q[9:0];
    end
  endgenerate

  apb_xfer_master u_xfer (
    .pclk    (pclk),
    .prst    (prst),
    .req     (xfer_req),
    .addr    (xfer_addr),
    .wr      (xfer_wr),
    .wdata   (xfer_wdata),
    .ack     (xfer_ack),
    .rdata   (xfer_rdata),
    .err     (xfer_err),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: an APB slave model with scripted TSR replies,
// wait states and errors; expected transfers are queued at stimulus time
// and compared as each APB transfer completes.
module tb_timer_seq_ctrl;

  localparam int P_GAP = 2;
  localparam int P_MAX = 4;

  logic       pclk = 1'b0;
  logic       prst;
  logic       start;
  logic       abort;
  logic [7:0] cfg_tdr;
  logic       cfg_dw;
  logic [1:0] cfg_clk;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [9:0] poll_cnt;
  logic [7:0] paddr;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  typedef struct packed {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [7:0] tsr_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         xfer_total = 0;
  int         wait_idx = -1;
  int         wait_n   = 0;
  int         err_idx  = -1;
  int         wcnt     = 0;
  logic [7:0] hold_addr;
  logic [7:0] hold_wdata;

  always #5 pclk = ~pclk;

  timer_seq_ctrl #(
    .ADDR_TCR (8'h00),
    .ADDR_TDR (8'h01),
    .ADDR_TSR (8'h02),
    .POLL_GAP (P_GAP),
    .POLL_MAX (P_MAX)
  ) dut (
    .pclk     (pclk),
    .prst     (prst),
    .start    (start),
    .abort    (abort),
    .cfg_tdr  (cfg_tdr),
    .cfg_dw   (cfg_dw),
    .cfg_clk  (cfg_clk),
    .busy     (busy),
    .done     (done),
    .status   (status),
    .poll_cnt (poll_cnt),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    xfer_t e;
    e.addr = a; e.wr = 1'b1; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a);
    xfer_t e;
    e.addr = a; e.wr = 1'b0; e.wdata = 8'h00;
    exp_q.push_back(e);
  endtask

  // Slave model and completion monitor, evaluated on the falling edge
  always @(negedge pclk) begin
    if (prst) begin
      pready = 1'b0; pslverr = 1'b0; prdata = 8'h00; wcnt = 0;
    end else if (psel && penable && !pready) begin
      if (wcnt == 0) begin
        hold_addr  = paddr;
        hold_wdata = pwdata;
      end else begin
        chk("hold_paddr", 32'(paddr), 32'(hold_addr));
        chk("hold_pwdata", 32'(pwdata), 32'(hold_wdata));
      end
      if ((xfer_total == wait_idx) && (wcnt < wait_n)) begin
        wcnt++;
      end else begin
        xfer_t e;
        pready  = 1'b1;
        pslverr = (xfer_total == err_idx);
        if (!pwrite && (tsr_q.size() > 0)) prdata = tsr_q.pop_front();
        else                               prdata = 8'h00;
        $display("xfer %s addr=%02h data=%02h err=%0d", pwrite ? "WR" : "RD",
                 paddr, pwrite ? pwdata : prdata, pslverr);
        chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("paddr", 32'(paddr), 32'(e.addr));
          chk("pwrite", 32'(pwrite), 32'(e.wr));
          if (e.wr) chk("pwdata", 32'(pwdata), 32'(e.wdata));
        end
        xfer_total++;
      end
    end else begin
      pready = 1'b0; pslverr = 1'b0; prdata = 8'h00; wcnt = 0;
    end
  end

  task automatic do_start(input logic [7:0] tdr, input logic dw, input logic [1:0] clk_sel);
    @(negedge pclk);
    start = 1'b1; cfg_tdr = tdr; cfg_dw = dw; cfg_clk = clk_sel;
    @(negedge pclk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while (!done && (cyc < budget)) begin
      @(negedge pclk);
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_end(input logic [1:0] st, input int pc);
    chk("status", 32'(status), 32'(st));
    chk("poll_cnt", 32'(poll_cnt), 32'(pc));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge pclk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    prst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_tdr = 8'h00; cfg_dw = 1'b0; cfg_clk = 2'b00;
    pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_poll_cnt", 32'(poll_cnt), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    prst = 1'b0;

    // Down count, flag on third read
    push_wr(8'h01, 8'hFF); push_wr(8'h00, 8'h80); push_wr(8'h00, 8'h32);
    push_rd(8'h02); push_rd(8'h02); push_rd(8'h02);
    push_wr(8'h02, 8'h00);
    tsr_q = '{8'h00, 8'h00, 8'h02};
    do_start(8'hFF, 1'b1, 2'd2);
    wait_done(500);
    check_end(2'b00, 3);

    // Up count: udf ignored, ovf completes; second start while busy is dropped
    push_wr(8'h01, 8'hF0); push_wr(8'h00, 8'h80); push_wr(8'h00, 8'h10);
    push_rd(8'h02); push_rd(8'h02);
    push_wr(8'h02, 8'h00);
    tsr_q = '{8'h02, 8'h01};
    do_start(8'hF0, 1'b0, 2'd0);
    repeat (3) @(negedge pclk);
    start = 1'b1; cfg_tdr = 8'h55; cfg_dw = 1'b1; cfg_clk = 2'd3;
    @(negedge pclk);
    start = 1'b0;
    wait_done(500);
    check_end(2'b00, 2);
    repeat (10) @(negedge pclk);
    chk("idle_after_filter", 32'(busy), 32'd0);

    // Timeout after POLL_MAX reads
    push_wr(8'h01, 8'h10); push_wr(8'h00, 8'h80); push_wr(8'h00, 8'h31);
    for (int i = 0; i < P_MAX; i++) push_rd(8'h02);
    push_wr(8'h00, 8'h00);
    tsr_q.delete();
    do_start(8'h10, 1'b1, 2'd1);
    wait_done(500);
    check_end(2'b01, P_MAX);

    // Wait states then slave error on the load write
    wait_idx = xfer_total + 1; wait_n = 3; err_idx = xfer_total + 1;
    push_wr(8'h01, 8'hAA); push_wr(8'h00, 8'h80);
    do_start(8'hAA, 1'b1, 2'd0);
    wait_done(500);
    check_end(2'b10, 0);
    repeat (20) @(negedge pclk);
    chk("no_xfer_after_err", 32'(psel), 32'd0);
    wait_idx = -1; err_idx = -1;

    // Abort during a waited TSR read that also carries the flag
    begin
      bit found;
      found = 1'b0;
      wait_idx = xfer_total + 3; wait_n = 3;
      push_wr(8'h01, 8'hC3); push_wr(8'h00, 8'h80); push_wr(8'h00, 8'h32);
      push_rd(8'h02);
      push_wr(8'h00, 8'h00);
      tsr_q = '{8'h02};
      do_start(8'hC3, 1'b1, 2'd2);
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge pclk);
        if (psel && penable && (paddr == 8'h02)) found = 1'b1;
      end
      chk("tsr_access_seen", 32'(found), 32'd1);
      abort = 1'b1;
      wait_done(500);
      check_end(2'b11, 1);
      repeat (5) @(negedge pclk);
      chk("abort_idle_no_effect", 32'(busy), 32'd0);
      abort = 1'b0;
      wait_idx = -1;
    end

    // Reset in the middle of an ACCESS phase, then a clean run
    begin
      bit found;
      found = 1'b0;
      wait_idx = xfer_total; wait_n = 6;
      push_wr(8'h01, 8'h77);
      do_start(8'h77, 1'b1, 2'd2);
      for (int i = 0; i < 50 && !found; i++) begin
        if (penable) found = 1'b1;
        else @(negedge pclk);
      end
      chk("access_seen", 32'(found), 32'd1);
      prst = 1'b1;
      @(negedge pclk);
      chk("mrst_psel", 32'(psel), 32'd0);
      chk("mrst_penable", 32'(penable), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_poll_cnt", 32'(poll_cnt), 32'd0);
      exp_q.delete();
      wait_idx = -1;
      prst = 1'b0;
      @(negedge pclk);
    end
    push_wr(8'h01, 8'h3C); push_wr(8'h00, 8'h80); push_wr(8'h00, 8'h32);
    push_rd(8'h02); push_rd(8'h02);
    push_wr(8'h02, 8'h00);
    tsr_q = '{8'h00, 8'h02};
    do_start(8'h3C, 1'b1, 2'd2);
    wait_done(500);
    check_end(2'b00, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
